// File: rtl/kyber_enc_loader.sv
// rtl/kyber_enc_loader.sv - host-byte sequencer feeding kyber_pke_enc over readin/readin_ok.
// Optional s_last length checking is enabled by defining KYBER_LOADER_LEN_CHECK_EN.
module kyber_enc_loader #(
    parameter int K          = 3,
    parameter int IDX_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    output logic [3:0]       req_type,
    output logic [IDX_W-1:0] req_len,
    input  logic [3:0]       core_input_type,
    input  logic             core_readin_ok,
    input  logic             core_done,
    output logic             core_readin,
    output logic             core_full_in,
    output logic [3:0]       core_data_type,
    output logic [7:0]       core_din,
    output logic [IDX_W-1:0] core_in_index,
    output logic             load_done,
    output logic             enc_done,
    output logic             err_seq,
    output logic             err_len
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [IDX_W-1:0] LEN_EK = IDX_W'(384 * K + 32);
    localparam logic [IDX_W-1:0] LEN_32 = IDX_W'(32);
    localparam logic [IDX_W-1:0] ONE    = IDX_W'(1);
    localparam logic [AW:0]      PTR_ONE = (AW + 1)'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [3:0]       cur_type;
    logic [IDX_W-1:0] len;
    logic [IDX_W-1:0] len_m1;
    logic [IDX_W-1:0] new_len;
    logic [IDX_W-1:0] wr_cnt;
    logic [IDX_W-1:0] rd_cnt;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             fifo_empty;
    logic             fifo_full;
    logic             type_ok;
    logic             in_load;
    logic             abort;
    logic             push;
    logic             pop;
    logic             at_last;
    logic             core_done_q;

    assign type_ok    = (core_input_type != 4'd0) && (core_input_type <= 4'd4);
    assign new_len    = (core_input_type == 4'd2) ? LEN_EK : LEN_32;
    assign len_m1     = len - ONE;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // A type change mid-load blocks both handshakes so nothing moves in the abort cycle.
    assign in_load    = (state == LOAD);
    assign abort      = in_load && (core_input_type != cur_type);

    assign s_ready     = in_load && !abort && !fifo_full && (wr_cnt < len);
    assign core_readin = in_load && !abort && !fifo_empty;
    assign push        = s_valid && s_ready;
    assign pop         = core_readin && core_readin_ok;
    assign at_last     = (rd_cnt == len_m1);

    assign core_full_in   = core_readin && at_last;
    assign core_din       = core_readin ? mem[rd_ptr[AW-1:0]] : 8'h00;
    assign core_in_index  = in_load ? rd_cnt : '0;
    assign core_data_type = (state != IDLE) ? cur_type : 4'd0;
    assign req_type       = (state != IDLE) ? cur_type : 4'd0;
    assign req_len        = (state != IDLE) ? len : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (type_ok) begin
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_nx = IDLE;
                end else if (pop && at_last) begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (core_input_type != cur_type) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= s_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_type  <= 4'd0;
            len       <= '0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            load_done <= 1'b0;
            err_seq   <= 1'b0;
        end else begin
            load_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (type_ok) begin
                        cur_type <= core_input_type;
                        len      <= new_len;
                        wr_cnt   <= '0;
                        rd_cnt   <= '0;
                        wr_ptr   <= '0;
                        rd_ptr   <= '0;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        err_seq <= 1'b1;
                        wr_cnt  <= '0;
                        rd_cnt  <= '0;
                        wr_ptr  <= '0;
                        rd_ptr  <= '0;
                    end else begin
                        if (push) begin
                            wr_ptr <= wr_ptr + PTR_ONE;
                            wr_cnt <= wr_cnt + ONE;
                        end
                        if (pop) begin
                            rd_ptr <= rd_ptr + PTR_ONE;
                            rd_cnt <= rd_cnt + ONE;
                            if (at_last) begin
                                load_done <= 1'b1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            core_done_q <= 1'b0;
            enc_done    <= 1'b0;
        end else begin
            core_done_q <= core_done;
            enc_done    <= core_done && !core_done_q;
        end
    end

`ifdef KYBER_LOADER_LEN_CHECK_EN
    // The byte count stays authoritative; a misplaced s_last only raises the flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_len <= 1'b0;
        end else if (push && (s_last != (wr_cnt == len_m1))) begin
            err_len <= 1'b1;
        end
    end
`else
    logic unused_last;
    assign unused_last = s_last;
    assign err_len     = 1'b0;
`endif

endmodule

// File: doc/kyber_enc_loader.md
Name: kyber_enc_loader

Overview:
- Synthesizable input sequencer in front of kyber_pke_enc; replaces bench-driven byte loading.
- Follows the core's input_type request and streams host bytes into the core over its readin/readin_ok handshake.
- Drives data_type, din, in_index and full_in.
- Parametrised in K, index width and buffer depth; derives per-type lengths, asserts full_in exactly on the last byte, and detects sequencing/length errors.

Parameters:
- K, 3, module rank (2, 3 or 4).
- IDX_W, 16, width of in_index and byte counters.
- FIFO_DEPTH, 4, byte buffer depth between host stream and core (power of 2, >=2).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- s_valid  in  1  host byte valid.
- s_ready  out  1  loader accepts host byte.
- s_data  in  8  host byte.
- s_last  in  1  host marks final byte of current input.
- req_type  out  4  input type currently requested from host (0 = none).
- req_len  out  IDX_W  byte count of requested input.
- core_input_type  in  4  core's requested type.
- core_readin_ok  in  1  core can take a byte this cycle.
- core_done  in  1  core encryption done.
- core_readin  out  1  byte presented to core.
- core_full_in  out  1  current byte is last of input.
- core_data_type  out  4  type tag for core.
- core_din  out  8  byte to core.
- core_in_index  out  IDX_W  byte index within input.
- load_done  out  1  one-cycle pulse per completed input.
- enc_done  out  1  one-cycle pulse, registered core_done rising edge.
- err_seq  out  1  sticky: core type changed mid-load.
- err_len  out  1  sticky: s_last mismatched length (feature only).

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; FIFO empty; counters 0; sticky errors cleared. Only reset clears sticky errors.
- Lengths:
  - type1 randomness r: 32.
  - type2 public key ekt: 384*K+32 (1184 @K=3).
  - type3 message: 32.
  - type4 seed: 32.
  - Other types are unsupported and never requested.
- Host transfer: s_valid & s_ready. Core transfer: core_readin & core_readin_ok.
- IDLE:
  - On a supported core_input_type, latch it as cur_type and load len.
  - Clear wr_cnt/rd_cnt; next cycle enter LOAD.
  - req_type = cur_type, req_len = len from LOAD entry until leaving WAIT.
- LOAD:
  - s_ready = !fifo_full & (wr_cnt < len). Each host transfer pushes a byte and increments wr_cnt. No pass-through: minimum latency host byte -> core_din is 1 cycle.
  - core_readin = !fifo_empty. core_din = FIFO head. core_in_index = rd_cnt. core_data_type = cur_type.
  - core_full_in = core_readin & (rd_cnt == len-1), combinational with that byte.
  - Core transfer pops the FIFO and increments rd_cnt.
  - Core transfer with rd_cnt == len-1: pulse load_done next cycle, go to WAIT.
  - Push and pop in the same cycle are legal, including at full (occupancy unchanged).
- WAIT:
  - s_ready=0, core_readin=0.
  - Stay until core_input_type != cur_type, then IDLE.
- Abort:
  - In LOAD, if core_input_type != cur_type, set err_seq, flush FIFO, zero counters, go to IDLE. No core transfer that cycle.
- core_data_type holds cur_type through WAIT; it is 0 in IDLE.
- enc_done: pulse the cycle after core_done rises; independent of state.
- Counters are IDX_W bits; len-1 never wraps for K<=4.

Optional Feature:
- Macro KYBER_LOADER_LEN_CHECK_EN.
- Defined:
  - On a host transfer with s_last=1 and wr_cnt != len-1, or s_last=0 and wr_cnt == len-1, set err_len.
  - The load proceeds unchanged; the byte count stays authoritative.
- Undefined: s_last ignored; err_len tied 0.

Test Plan:
- K=3, core_input_type=2, host streams continuously, core_readin_ok=1 -> 1184 core transfers, in_index 0..1183 in order, core_full_in high only with index 1183, load_done pulses once, req_len=1184.
- core_input_type=1, core_readin_ok toggles 1/0 each cycle, host always valid -> FIFO fills and s_ready drops; 32 bytes delivered in order with no loss or duplication; core_full_in with index 31.
- Type sequence 1->2->3->4, then core_done pulse -> four load_done pulses, core_data_type matches each type, enc_done one cycle after core_done rises.
- core_input_type switches 2->3 after 100 core transfers -> err_seq=1, FIFO flushed, new load of type 3 starts at in_index 0 with 32 bytes.
- With KYBER_LOADER_LEN_CHECK_EN, type 1, s_last on byte 20 -> err_len=1, all 32 bytes still delivered. Without the macro -> err_len stays 0.
- reset_n pulsed low mid type-2 load at index 500 -> all outputs 0 immediately (async), state IDLE; after release a fresh load restarts at index 0.
